// File: rtl/control_edicion.sv
// Edit controller for the clock/date/timer set-up screen: loads a field group from the RTC,
// steps fields with up/down releases and commits over wr_req/wr_ack. Optional macro: DAY_CLAMP_EN.
module control_edicion #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fecha,
   input  logic       hora,
   input  logic       timer,
   input  logic [1:0] posicion_x,
   input  logic       boton_u,
   input  logic       boton_d,
   input  logic       boton_c,
   input  logic [6:0] rd_c0,
   input  logic [6:0] rd_c1,
   input  logic [6:0] rd_c2,
   input  logic       wr_ack,
   output logic [6:0] campo0,
   output logic [6:0] campo1,
   output logic [6:0] campo2,
   output logic       editando,
   output logic       wr_req,
   output logic [1:0] wr_grupo,
   output logic       wr_err
);

   // Write handshake: wr_req rises the cycle after a commit release and stays high, with
   // wr_grupo and the campos frozen, until the first cycle wr_ack is seen high or the
   // timeout expires; it drops on the following cycle. wr_ack outside WRITE is ignored.

   typedef enum logic [1:0] {IDLE, LOAD, EDIT, WRITE} estado_t;

   localparam logic [1:0] G_NONE  = 2'd0;
   localparam logic [1:0] G_HORA  = 2'd1;
   localparam logic [1:0] G_FECHA = 2'd2;
   localparam logic [1:0] G_TIMER = 2'd3;
   localparam logic [8:0] TOUT    = 9'(ACK_TIMEOUT);

   estado_t         estado, estado_n;
   logic [1:0]      grupo, grupo_lat, grupo_lat_n;
   logic [2:0][6:0] campos, campos_n, rd;
   logic            arm_u, arm_d, arm_c;
   logic            ev_u, ev_d, ev_c;
   logic [7:0]      cnt, cnt_n;
   logic            cnt_fin;
   logic            wr_err_n;
   logic [6:0]      v, lo, hi, hi_c0;

   function automatic logic [6:0] lim_min(input logic [1:0] g, input logic [1:0] f);
      return (g == G_FECHA && f != 2'd2) ? 7'd1 : 7'd0;
   endfunction

   function automatic logic [6:0] lim_max(input logic [1:0] g, input logic [1:0] f);
      case (f)
         2'd0:    return (g == G_FECHA) ? 7'd31 : 7'd23;
         2'd1:    return (g == G_FECHA) ? 7'd12 : 7'd59;
         default: return (g == G_FECHA) ? 7'd99 : 7'd59;
      endcase
   endfunction

`ifdef DAY_CLAMP_EN
   // February is always 28; out-of-range months never reach here but fall back to 31.
   function automatic logic [6:0] month_len(input logic [6:0] m);
      case (m)
         7'd2:                      return 7'd28;
         7'd4, 7'd6, 7'd9, 7'd11:   return 7'd30;
         default:                   return 7'd31;
      endcase
   endfunction
`endif

   assign grupo = hora ? G_HORA : (fecha ? G_FECHA : (timer ? G_TIMER : G_NONE));
   assign rd    = {rd_c2, rd_c1, rd_c0};

   // Release events only count while editing; arm flags are held clear elsewhere.
   assign ev_u = (estado == EDIT) && arm_u && !boton_u;
   assign ev_d = (estado == EDIT) && arm_d && !boton_d;
   assign ev_c = (estado == EDIT) && arm_c && !boton_c;

   assign cnt_fin = ({1'b0, cnt} + 9'd1) >= TOUT;

   always_comb begin
      estado_n    = estado;
      grupo_lat_n = grupo_lat;
      campos_n    = campos;
      cnt_n       = 8'd0;
      wr_err_n    = 1'b0;
      v           = 7'd0;
      lo          = 7'd0;
      hi          = 7'd0;
`ifdef DAY_CLAMP_EN
      hi_c0 = (grupo_lat == G_FECHA) ? month_len(campos[1]) : lim_max(grupo_lat, 2'd0);
`else
      hi_c0 = lim_max(grupo_lat, 2'd0);
`endif

      case (estado)
         IDLE: begin
            if (grupo != G_NONE) begin
               estado_n    = LOAD;
               grupo_lat_n = grupo;
            end
         end

         LOAD: begin
            for (int i = 0; i < 3; i++) begin
               v  = rd[i];
               lo = lim_min(grupo_lat, 2'(i));
               hi = lim_max(grupo_lat, 2'(i));
               campos_n[i] = (v < lo || v > hi) ? lo : v;
            end
            estado_n = EDIT;
         end

         EDIT: begin
            if (grupo == G_NONE) begin
               estado_n = IDLE;
            end else if (grupo != grupo_lat) begin
               estado_n    = LOAD;
               grupo_lat_n = grupo;
            end else if (ev_c) begin
               estado_n = WRITE;
            end else if ((ev_u ^ ev_d) && posicion_x != 2'd3) begin
               v  = campos[posicion_x];
               lo = lim_min(grupo_lat, posicion_x);
               hi = (posicion_x == 2'd0) ? hi_c0 : lim_max(grupo_lat, posicion_x);
               if (ev_u)
                  campos_n[posicion_x] = (v >= hi) ? lo : v + 7'd1;
               else
                  campos_n[posicion_x] = (v <= lo) ? hi : v - 7'd1;
            end
         end

         WRITE: begin
            // Mode changes are only looked at on exit; the request is never aborted.
            if (wr_ack || cnt_fin) begin
               estado_n = (grupo != G_NONE && grupo == grupo_lat) ? EDIT : IDLE;
               wr_err_n = !wr_ack;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end

         default: estado_n = IDLE;
      endcase

`ifdef DAY_CLAMP_EN
      // Day follows the month bound whenever the month moves or a date is loaded.
      if (grupo_lat == G_FECHA && (estado == LOAD || estado == EDIT) &&
          campos_n[0] > month_len(campos_n[1]))
         campos_n[0] = month_len(campos_n[1]);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado    <= IDLE;
         grupo_lat <= G_NONE;
         campos    <= '0;
         cnt       <= 8'd0;
         wr_err    <= 1'b0;
         wr_req    <= 1'b0;
         wr_grupo  <= G_NONE;
         arm_u     <= 1'b0;
         arm_d     <= 1'b0;
         arm_c     <= 1'b0;
      end else begin
         estado    <= estado_n;
         grupo_lat <= grupo_lat_n;
         campos    <= campos_n;
         cnt       <= cnt_n;
         wr_err    <= wr_err_n;
         wr_req    <= (estado_n == WRITE);
         wr_grupo  <= (estado_n == WRITE) ? grupo_lat_n : G_NONE;
         arm_u     <= (estado == EDIT) && boton_u;
         arm_d     <= (estado == EDIT) && boton_d;
         arm_c     <= (estado == EDIT) && boton_c;
      end
   end

   assign editando = (estado == EDIT) || (estado == WRITE);
   assign campo0   = campos[0];
   assign campo1   = campos[1];
   assign campo2   = campos[2];

endmodule

// File: tb/tb_control_edicion.sv
// Directed bench for control_edicion: expected output snapshots and write transactions are
// queued by the driver and consumed by independent monitors.
module tb_control_edicion;

   localparam int TO = 8;
`ifdef DAY_CLAMP_EN
   localparam int CD = 28;
`else
   localparam int CD = 31;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       fecha, hora, timer;
   logic [1:0] posicion_x;
   logic       boton_u, boton_d, boton_c;
   logic [6:0] rd_c0, rd_c1, rd_c2;
   logic       wr_ack;
   logic [6:0] campo0, campo1, campo2;
   logic       editando, wr_req, wr_err;
   logic [1:0] wr_grupo;

   logic [24:0] exp_q[$];
   string       name_q[$];
   logic [22:0] exp_wr_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic        prev_req = 1'b0;
   logic [24:0] got, e;
   logic [22:0] got_wr, e_wr;
   string       nm;

   always #5 clk = ~clk;

   control_edicion #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .fecha(fecha), .hora(hora), .timer(timer),
      .posicion_x(posicion_x), .boton_u(boton_u), .boton_d(boton_d), .boton_c(boton_c),
      .rd_c0(rd_c0), .rd_c1(rd_c1), .rd_c2(rd_c2), .wr_ack(wr_ack),
      .campo0(campo0), .campo1(campo1), .campo2(campo2), .editando(editando),
      .wr_req(wr_req), .wr_grupo(wr_grupo), .wr_err(wr_err)
   );

   assign got    = {campo0, campo1, campo2, editando, wr_req, wr_grupo, wr_err};
   assign got_wr = {wr_grupo, campo0, campo1, campo2};

   function automatic logic [24:0] mk(input int c0, input int c1, input int c2,
                                      input int ed, input int rq, input int gr, input int er);
      return {7'(c0), 7'(c1), 7'(c2), 1'(ed), 1'(rq), 2'(gr), 1'(er)};
   endfunction

   // Snapshot monitor and write-transaction monitor.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got c=%0d/%0d/%0d ed=%b req=%b grp=%0d err=%b, expected c=%0d/%0d/%0d ed=%b req=%b grp=%0d err=%b",
                     nm, got[24:18], got[17:11], got[10:4], got[3], got[2], got[1:0], got[0],
                     e[24:18], e[17:11], e[10:4], e[3], e[2], e[1:0], e[0]);
         end
      end
      if (wr_req && !prev_req) begin
         n_vec++;
         if (exp_wr_q.size() == 0) begin
            n_bad++;
            $display("FAIL wr_txn: unexpected write grp=%0d c=%0d/%0d/%0d, none expected",
                     wr_grupo, campo0, campo1, campo2);
         end else begin
            e_wr = exp_wr_q.pop_front();
            if (got_wr !== e_wr) begin
               n_bad++;
               $display("FAIL wr_txn: got grp=%0d c=%0d/%0d/%0d, expected grp=%0d c=%0d/%0d/%0d",
                        got_wr[22:21], got_wr[20:14], got_wr[13:7], got_wr[6:0],
                        e_wr[22:21], e_wr[20:14], e_wr[13:7], e_wr[6:0]);
            end
         end
      end
      prev_req = wr_req;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [24:0] x);
      exp_q.push_back(x);
      name_q.push_back(name);
   endtask

   task automatic press(input logic u, input logic d, input logic c);
      boton_u = u; boton_d = d; boton_c = c;
      tick(1);
      boton_u = 1'b0; boton_d = 1'b0; boton_c = 1'b0;
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; fecha = 1'b0; hora = 1'b0; timer = 1'b0; posicion_x = 2'd0;
      boton_u = 1'b0; boton_d = 1'b0; boton_c = 1'b0; wr_ack = 1'b0;
      rd_c0 = 7'd0; rd_c1 = 7'd0; rd_c2 = 7'd0;
      tick(2);
      chk("reset", mk(0, 0, 0, 0, 0, 0, 0)); tick(1);
      reset = 1'b0; tick(1);

      // hora: IDLE -> LOAD -> EDIT
      hora = 1'b1; rd_c0 = 7'd23; rd_c1 = 7'd59; rd_c2 = 7'd58;
      chk("hora_idle", mk(0, 0, 0, 0, 0, 0, 0)); tick(1);
      chk("hora_load", mk(0, 0, 0, 0, 0, 0, 0)); tick(1);
      chk("hora_edit", mk(23, 59, 58, 1, 0, 0, 0));

      posicion_x = 2'd0;
      press(1, 0, 0); chk("up_wrap_c0", mk(0, 59, 58, 1, 0, 0, 0));
      press(0, 1, 0); chk("dn_wrap_c0", mk(23, 59, 58, 1, 0, 0, 0));
      press(1, 1, 0); chk("up_dn_same", mk(23, 59, 58, 1, 0, 0, 0));
      posicion_x = 2'd1;
      press(1, 0, 0); chk("up_wrap_c1", mk(23, 0, 58, 1, 0, 0, 0));
      posicion_x = 2'd3;
      press(1, 0, 0); chk("pos3_ignored", mk(23, 0, 58, 1, 0, 0, 0));
      posicion_x = 2'd2;
      boton_u = 1'b1; tick(3); boton_u = 1'b0; tick(1);
      chk("held_one_step", mk(23, 0, 59, 1, 0, 0, 0));

      // fecha with out-of-range RTC values
      hora = 1'b0; fecha = 1'b1; rd_c0 = 7'd0; rd_c1 = 7'd13; rd_c2 = 7'd50;
      tick(1); chk("fecha_load", mk(23, 0, 59, 0, 0, 0, 0));
      tick(1); chk("fecha_edit", mk(1, 1, 50, 1, 0, 0, 0));
      posicion_x = 2'd0;
      press(0, 1, 0); chk("day_dn_wrap", mk(31, 1, 50, 1, 0, 0, 0));
      posicion_x = 2'd1;
      press(1, 0, 0); chk("month_up_clamp", mk(CD, 2, 50, 1, 0, 0, 0));
      press(0, 1, 0); chk("month_dn", mk(CD, 1, 50, 1, 0, 0, 0));
      press(0, 1, 0); chk("month_dn_wrap", mk(CD, 12, 50, 1, 0, 0, 0));

      // timer: commit acknowledged after 5 cycles
      fecha = 1'b0; timer = 1'b1; rd_c0 = 7'd5; rd_c1 = 7'd6; rd_c2 = 7'd7;
      tick(1); chk("timer_load", mk(CD, 12, 50, 0, 0, 0, 0));
      tick(1); chk("timer_edit", mk(5, 6, 7, 1, 0, 0, 0));
      wr_ack = 1'b1; tick(1); wr_ack = 1'b0;
      chk("ack_outside_write", mk(5, 6, 7, 1, 0, 0, 0));
      exp_wr_q.push_back({2'd3, 7'd5, 7'd6, 7'd7});
      press(1, 0, 1); chk("commit_wins", mk(5, 6, 7, 1, 1, 3, 0));
      press(1, 0, 0); tick(2);
      chk("write_frozen", mk(5, 6, 7, 1, 1, 3, 0));
      wr_ack = 1'b1; tick(1); wr_ack = 1'b0;
      chk("ack_exit", mk(5, 6, 7, 1, 0, 0, 0)); tick(1);
      chk("ack_no_err", mk(5, 6, 7, 1, 0, 0, 0));

      // timeout with the mode dropped during the wait
      exp_wr_q.push_back({2'd3, 7'd5, 7'd6, 7'd7});
      press(0, 0, 1); chk("commit_to", mk(5, 6, 7, 1, 1, 3, 0));
      timer = 1'b0;
      for (int i = 2; i <= TO; i++) begin
         tick(1); chk("wait_ack", mk(5, 6, 7, 1, 1, 3, 0));
      end
      tick(1); chk("timeout_err", mk(5, 6, 7, 0, 0, 0, 1));
      tick(1); chk("err_one_cycle", mk(5, 6, 7, 0, 0, 0, 0));

      // hora wins over timer; reset in the middle of a write
      hora = 1'b1; timer = 1'b1; rd_c0 = 7'd1; rd_c1 = 7'd2; rd_c2 = 7'd3;
      tick(2); chk("prio_edit", mk(1, 2, 3, 1, 0, 0, 0));
      exp_wr_q.push_back({2'd1, 7'd1, 7'd2, 7'd3});
      press(0, 0, 1); chk("commit_hora", mk(1, 2, 3, 1, 1, 1, 0));
      tick(2);
      reset = 1'b1; chk("reset_mid_write", mk(0, 0, 0, 0, 0, 0, 0)); tick(1);
      chk("reset_held", mk(0, 0, 0, 0, 0, 0, 0));
      reset = 1'b0; hora = 1'b0; timer = 1'b0; tick(1);
      chk("idle_after_reset", mk(0, 0, 0, 0, 0, 0, 0));
      tick(2);

      n_vec++;
      if (exp_q.size() != 0 || exp_wr_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d snapshots and %0d writes still pending, expected 0 and 0",
                  exp_q.size(), exp_wr_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/control_edicion.md
Name: control_edicion

Overview:
- Edit controller for the clock/date/timer set-up screen.
- Driven by the mode selects (fecha/hora/timer) and the 2-bit cursor position from the cursor-position counter.
- Loads the active group's three fields from the RTC read path, lets the user step the field under the cursor with up/down buttons, and commits the group to the RTC write path over a req/ack handshake.

Parameters:
ACK_TIMEOUT, 255, max cycles WRITE waits for wr_ack before abandoning; range 1..255; counter is 8 bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
fecha  input  1  date-edit mode select
hora  input  1  time-edit mode select
timer  input  1  timer-edit mode select
posicion_x  input  2  cursor from cursor counter; 0/1/2 select campo0/1/2; 3 = no field
boton_u  input  1  increment button, debounced level
boton_d  input  1  decrement button, debounced level
boton_c  input  1  commit button, debounced level
rd_c0  input  7  current RTC value of field 0 of selected group, binary
rd_c1  input  7  current RTC value of field 1, binary
rd_c2  input  7  current RTC value of field 2, binary
wr_ack  input  1  RTC write interface acknowledge, 1-cycle or level
campo0  output  7  edited field 0 (hours / day / timer hours)
campo1  output  7  edited field 1 (minutes / month / timer minutes)
campo2  output  7  edited field 2 (seconds / year / timer seconds)
editando  output  1  high in EDIT and WRITE
wr_req  output  1  write request, registered
wr_grupo  output  2  group being written: 1=hora, 2=fecha, 3=timer, 0=none
wr_err  output  1  1-cycle pulse on write timeout

Behaviour:
- Reset: state IDLE; campo0..2=0; editando=0; wr_req=0; wr_grupo=0; wr_err=0; button arm flags=0; timeout counter=0.
- Group decode, priority hora > fecha > timer; none asserted = group 0.
- Ranges:
  - hora and timer: c0 0..23, c1 0..59, c2 0..59.
  - fecha: c0 1..31, c1 1..12, c2 0..99.
- Button events: button high sets its arm flag; first cycle low with flag set = release event; flag clears. One step per press.
- Buttons are ignored and flags are cleared outside EDIT.
- IDLE:
  - editando=0, wr_req=0, wr_grupo=0.
  - Group != 0 -> LOAD; group latched.
- LOAD (exactly 1 cycle):
  - campoN <= rd_cN.
  - Any value outside its range loads that field's minimum.
  - -> EDIT.
- EDIT:
  - editando=1.
  - Up release: selected field +1; at max wraps to min.
  - Down release: selected field -1; at min wraps to max.
  - Up and down released in the same cycle: no change.
  - posicion_x=3: up/down ignored.
  - Commit release -> WRITE: wr_req=1 and wr_grupo=latched group from the next cycle. Commit wins over same-cycle up/down; fields are not stepped.
  - Group falls to 0 -> IDLE; edits discarded; campos hold their last value.
  - Group changes to a different nonzero group -> LOAD.
- WRITE:
  - wr_req, wr_grupo and campos frozen; buttons ignored.
  - Counter increments each cycle.
  - wr_ack=1 -> wr_req deasserts next cycle; counter=0. Then EDIT if group unchanged and nonzero, otherwise IDLE.
  - Counter reaches ACK_TIMEOUT with no ack -> wr_err pulses 1 cycle; wr_req drops; counter=0. Same exit rule as the ack case.
  - A mode change during WRITE does not abort the request; it is evaluated only on exit.
- wr_ack outside WRITE is ignored.
- Reset asserted mid-WRITE: wr_req drops immediately (asynchronous reset); no wr_err.

Optional Feature:
DAY_CLAMP_EN
- Defined:
  - In fecha group, the upper bound of c0 equals the month length for the current c1: 31/28/31/30/31/30/31/31/30/31/30/31; February is always 28.
  - Whenever c1 changes, or on LOAD, c0 is clamped down to that bound in the same cycle.
  - Up-wrap on c0 uses that bound.
- Undefined: c0 range is flat 1..31 for every month.

Test Plan:
- Reset mid-operation, then hora=1 with rd_c=23/59/58 -> LOAD then EDIT; campo=23/59/58; editando=1 two cycles after hora rises.
- hora, posicion_x=0, campo0=23, one up press/release -> campo0=0. One down press/release -> campo0=23. Up and down released in the same cycle -> unchanged.
- fecha, rd_c=0/13/50 -> campo0=1, campo1=1, campo2=50 (out-of-range fields take the minimum).
- EDIT timer, commit release -> wr_req=1, wr_grupo=3. wr_ack pulse after 5 cycles -> wr_req=0 next cycle, state returns to EDIT, wr_err stays 0.
- Commit with wr_ack tied 0, ACK_TIMEOUT=8 -> wr_req high 8 cycles, then wr_err high for exactly 1 cycle and wr_req=0. Mode dropped during the wait -> IDLE after the timeout.
- DAY_CLAMP_EN defined: fecha, campo0=31, campo1=1, step month up -> campo1=2, campo0=28 in the same cycle. Macro undefined -> campo0 stays 31.
